// File: rtl/latch_level_reader.sv
// latch_level_reader: synchronises and glitch-filters an asynchronous level,
// then queues timestamped rise/fall records for a valid/ready consumer.
module latch_level_reader #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 4,
  parameter int TS_W          = 8,
  parameter int DEPTH         = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         level_in,
  output logic                         level_q,
  output logic                         ev_valid,
  input  logic                         ev_ready,
  output logic                         ev_rise,
  output logic [TS_W-1:0]              ev_ts,
  output logic [$clog2(DEPTH+1)-1:0]   ev_count,
  output logic                         overflow
);
  localparam int CW = $clog2(DEPTH+1);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic {IDLE, PEND} state_t;
  state_t state, state_next;
  logic [SYNC_STAGES-1:0] sync;
  logic [7:0] cnt, cnt_cur, cnt_next;
  logic [TS_W-1:0] ts;
  logic [DEPTH-1:0] rise_mem;
  logic [TS_W-1:0] ts_mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic s_out, fire, pop, full, wr;
  assign s_out    = sync[SYNC_STAGES-1];
  assign ev_valid = ev_count != '0;
  assign ev_rise  = rise_mem[rp];
  assign ev_ts    = ts_mem[rp];
  assign pop      = ev_valid && ev_ready;
  assign full     = ev_count == CW'(DEPTH);
  assign wr       = fire && (!full || pop);
  always_comb begin
    state_next = IDLE;
    cnt_next   = '0;
    fire       = 1'b0;
    cnt_cur    = (state == PEND) ? cnt : '0;
    if (s_out != level_q) begin
      fire       = cnt_cur == 8'(STABLE_CYCLES - 1);
      state_next = fire ? IDLE : PEND;
      cnt_next   = fire ? '0 : cnt_cur + 8'd1;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync    <= '0;
      state   <= IDLE;
      cnt     <= '0;
      level_q <= 1'b0;
      ts      <= '0;
    end else begin
      sync    <= {sync[SYNC_STAGES-2:0], level_in};
      state   <= state_next;
      cnt     <= cnt_next;
      level_q <= fire ? ~level_q : level_q;
      ts      <= ts + TS_W'(1);
    end
  end
  // Records carry the timestamp visible during the cycle the new level_q is shown.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rise_mem <= '0;
      for (int i = 0; i < DEPTH; i++) ts_mem[i] <= '0;
      wp       <= '0;
      rp       <= '0;
      ev_count <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr) begin
        rise_mem[wp] <= ~level_q;
        ts_mem[wp]   <= ts + TS_W'(1);
        wp           <= wp + AW'(1);
      end
      if (pop) rp <= rp + AW'(1);
      ev_count <= ev_count + CW'(wr) - CW'(pop);
      if (fire && full && !pop) overflow <= 1'b1;
    end
  end
endmodule

// File: doc/latch_level_reader.md
Name: latch_level_reader

Overview:
- Read-side companion to the team's level-sensitive storage elements (D latch outputs, asynchronous level flags).
- Takes one asynchronous level, synchronises it into the clk domain and filters glitches.
- Converts each qualified level change into a timestamped event record and buffers records in a small FIFO.
- A downstream consumer drains the FIFO through a valid/ready handshake.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flops (legal range 2..4).
- STABLE_CYCLES, 4, consecutive identical synchronised samples needed before a level change is accepted (legal range 1..255).
- TS_W, 8, timestamp counter width.
- DEPTH, 4, event FIFO depth (power of two, minimum 2).

Ports:
- clk, input, 1: single clock; all state changes on its rising edge.
- rst, input, 1: reset, asynchronous assert, active-low (rst=0 resets); release is synchronous to clk.
- level_in, input, 1: asynchronous level to observe, e.g. a latch Q.
- level_q, output, 1: filtered, synchronised level.
- ev_valid, output, 1: FIFO head record is valid.
- ev_ready, input, 1: consumer accepts the head record.
- ev_rise, output, 1: head record type; 1 = rising change, 0 = falling change.
- ev_ts, output, TS_W: timestamp of the head record.
- ev_count, output, 3 (enough for 0..DEPTH at default): number of records currently held.
- overflow, output, 1: sticky, set when an event is dropped.

Behaviour:
- Reset (rst=0, asynchronous) forces these values:
  - sync chain = 0, level_q = 0, stability counter = 0, timestamp = 0;
  - FIFO empty, ev_valid = 0, ev_rise = 0, ev_ts = 0, ev_count = 0, overflow = 0.
- Reset asserted mid-operation discards all records immediately.
- Timestamp: free-running TS_W counter, +1 every cycle, wraps from 2^TS_W-1 to 0 with no flag.
- Synchroniser: level_in passes through SYNC_STAGES flops. s_out is the last stage.
- Filter state machine, two states:
  - IDLE (s_out == level_q): counter held at 0.
  - PEND (s_out != level_q): counter +1 per cycle. If s_out returns to level_q before the count completes, go back to IDLE and clear the counter; the glitch is ignored.
  - When the counter reaches STABLE_CYCLES, on that edge: level_q toggles, an event is generated, the counter clears, and the state returns to IDLE.
- Latency: a clean step on level_in reaches level_q after SYNC_STAGES + STABLE_CYCLES rising edges, ±1 cycle for input phase.
- Event record: {rise = new level_q, ts = timestamp value on the cycle level_q updates}.
- FIFO write:
  - If not full, the record is written.
  - If full and no pop happens in the same cycle, the record is dropped and overflow is set. overflow stays set until reset.
- FIFO read:
  - ev_valid = (ev_count != 0).
  - A pop happens on an edge where ev_valid && ev_ready.
  - ev_rise and ev_ts always show the head record; their value is don't-care when ev_valid = 0 (bench must not check them then).
- Simultaneous push and pop:
  - Both occur; ev_count unchanged.
  - When full, a same-cycle pop frees space and the push succeeds, with no overflow.
  - When empty, the new record is not visible until the next cycle. No fall-through: ev_valid rises the cycle after the push.
- Handshake rules:
  - While ev_valid = 1 and ev_ready = 0, the head record stays stable.
  - ev_ready while empty has no effect.
- Pointers: log2(DEPTH) bits, wrap naturally; full/empty decided from ev_count.

Test Plan:
- Clean rise, defaults: rst=0 for 3 cycles, release; level_in 0→1 at cycle 10 and held → level_q=1 by cycle 16–17; one record with ev_rise=1 and ev_ts equal to the timestamp on that cycle; ev_count=1.
- Glitch rejection: level_in pulses high for 3 cycles (< STABLE_CYCLES) → level_q stays 0, ev_valid stays 0, no record; then a 4-cycle-plus hold → exactly one record.
- Backpressure and overflow: ev_ready=0, six qualified alternating edges → ev_count saturates at 4, overflow=1; the 4 records drained in order read rise, fall, rise, fall with increasing ev_ts; the last two events are lost.
- Full + simultaneous pop: FIFO full, ev_ready=1 on the cycle a new event is pushed → ev_count stays 4, overflow stays 0, the new record appears last.
- Timestamp wrap: TS_W=4; events spaced 10 cycles apart across the 15→0 wrap → ev_ts values differ by 10 mod 16; no flag is raised.
- Async reset mid-stream: FIFO holding 2 records, level_q=1; drive rst=0 between clock edges → level_q, ev_valid, ev_count and overflow read 0 immediately, before the next clk edge; after release with level_in=1, one rising record is generated after the filter latency.
